mux_operand_sequencer: RTL and testbench



---
 rtl/mux_operand_sequencer_pkg.sv | 20 ++
 rtl/mux_operand_sequencer_if.sv | 26 ++
 rtl/mux_operand_sequencer_dwell_counter.sv | 29 ++
 rtl/mux_operand_sequencer.sv | 104 ++++++++++
 tb/tb_mux_operand_sequencer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_operand_sequencer_pkg.sv
// Shared types and defaults for the mux operand sequencer: FSM state encoding,
// default operand width and phase dwell length.
package mux_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PHASE_A   = 2'd1,
    ST_PHASE_B   = 2'd2,
    ST_PHASE_OFF = 2'd3
  } seq_state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DWELL = 5;

  // One spare bit above what DWELL-1 needs so the saturating count never wraps.
  function automatic int cnt_width(input int dwell);
    return $clog2(dwell) + 1;
  endfunction

endpackage

// File: rtl/mux_operand_sequencer_if.sv
// Operand handshake plus mux-facing drive signals of the sequencer.
// The slave modport is the sequencer, the master modport is its environment.
interface mux_operand_sequencer_if #(
  parameter int WIDTH = mux_seq_pkg::DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] mux_a;
  logic [WIDTH-1:0] mux_b;
  logic             mux_s;
  logic             mux_e;
  logic             busy;
  logic             done;

  modport slave (
    input  in_valid, in_a, in_b,
    output in_ready, mux_a, mux_b, mux_s, mux_e, busy, done
  );

  modport master (
    output in_valid, in_a, in_b,
    input  in_ready, mux_a, mux_b, mux_s, mux_e, busy, done
  );
endinterface

// File: rtl/mux_operand_sequencer_dwell_counter.sv
// Saturating per-phase cycle counter; terminal marks the last cycle of a phase.
module dwell_counter
  import mux_seq_pkg::*;
#(
  parameter int DWELL = DEF_DWELL
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic terminal
);

  localparam int            CW   = cnt_width(DWELL);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] r_cnt;

  // Holds at LAST while idle so the count can never wrap.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (r_cnt != LAST) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign terminal = (r_cnt == LAST);

endmodule

// File: rtl/mux_operand_sequencer.sv
// Plays accepted A/B operand pairs onto a quad 2-to-1 mux as show-A, show-B,
// disabled phases, with a one-deep pending buffer for back-to-back pairs.
module mux_operand_sequencer
  import mux_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DWELL = DEF_DWELL
) (
  input logic                   clk,
  input logic                   rst,
  mux_operand_sequencer_if.slave sq
);

  if (DWELL < 1) begin : g_bad_dwell
    $error("DWELL must be at least 1");
  end

  seq_state_t       r_state;
  logic [WIDTH-1:0] r_act_a;
  logic [WIDTH-1:0] r_act_b;
  logic [WIDTH-1:0] r_pend_a;
  logic [WIDTH-1:0] r_pend_b;
  logic             r_pend_vld;

  logic w_ready;
  logic w_hs;
  logic w_terminal;
  logic w_clear;

  assign w_ready = ~r_pend_vld & ~rst;
  assign w_hs    = sq.in_valid & w_ready;

  // Every phase end is a state entry (OFF->A included); from IDLE only a handshake is.
  assign w_clear = (r_state == ST_IDLE) ? w_hs : w_terminal;

  dwell_counter #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_clear),
    .terminal(w_terminal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_act_a    <= '0;
      r_act_b    <= '0;
      r_pend_vld <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_act_a <= sq.in_a;
            r_act_b <= sq.in_b;
            r_state <= ST_PHASE_A;
          end
        end
        ST_PHASE_A, ST_PHASE_B: begin
          if (w_hs) begin
            r_pend_a   <= sq.in_a;
            r_pend_b   <= sq.in_b;
            r_pend_vld <= 1'b1;
          end
          if (w_terminal) begin
            r_state <= (r_state == ST_PHASE_A) ? ST_PHASE_B : ST_PHASE_OFF;
          end
        end
        ST_PHASE_OFF: begin
          if (w_terminal) begin
            // Pending pair wins; otherwise a same-cycle offer bypasses the buffer.
            if (r_pend_vld) begin
              r_act_a    <= r_pend_a;
              r_act_b    <= r_pend_b;
              r_pend_vld <= 1'b0;
              r_state    <= ST_PHASE_A;
            end else if (w_hs) begin
              r_act_a <= sq.in_a;
              r_act_b <= sq.in_b;
              r_state <= ST_PHASE_A;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (w_hs) begin
            r_pend_a   <= sq.in_a;
            r_pend_b   <= sq.in_b;
            r_pend_vld <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sq.in_ready = w_ready;
  assign sq.mux_a    = r_act_a;
  assign sq.mux_b    = r_act_b;
  assign sq.mux_e    = (r_state == ST_PHASE_A) || (r_state == ST_PHASE_B);
  assign sq.mux_s    = (r_state == ST_PHASE_B);
  assign sq.busy     = (r_state != ST_IDLE);
  assign sq.done     = (r_state == ST_PHASE_OFF) && w_terminal && !rst;

endmodule

// File: tb/tb_mux_operand_sequencer.sv
// Directed bench for mux_operand_sequencer with DWELL=5 and DWELL=1 instances.
module tb_mux_operand_sequencer;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mux_operand_sequencer_if #(.WIDTH(W)) bus5 ();
  mux_operand_sequencer_if #(.WIDTH(W)) bus1 ();

  mux_operand_sequencer #(.WIDTH(W), .DWELL(5)) dut5 (
    .clk(clk),
    .rst(rst),
    .sq (bus5)
  );

  mux_operand_sequencer #(.WIDTH(W), .DWELL(1)) dut1 (
    .clk(clk),
    .rst(rst),
    .sq (bus1)
  );

  // Output of the downstream quad mux: disabled drives zero.
  logic [W-1:0] y5, y1;
  assign y5 = bus5.mux_e ? (bus5.mux_s ? bus5.mux_b : bus5.mux_a) : '0;
  assign y1 = bus1.mux_e ? (bus1.mux_s ? bus1.mux_b : bus1.mux_a) : '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus5.in_valid = 1'b0; bus5.in_a = '0; bus5.in_b = '0;
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0;
    rst = 1'b1;
    step(); step(); step();
    checks++;
    if ({bus5.busy, bus5.mux_e, bus5.mux_s, bus5.done, bus5.in_ready, bus5.mux_a, bus5.mux_b} !== 13'b0) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", {bus5.busy, bus5.mux_e, bus5.mux_s, bus5.done,
               bus5.in_ready, bus5.mux_a, bus5.mux_b}, 13'b0);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus5.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset got=%b exp=1", bus5.in_ready);
    end
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if ({bus5.busy, bus5.mux_e, bus5.done, bus5.in_ready} !== 4'b0001) begin
        failures++;
        $display("FAIL idle_cyc%0d busy/e/done/rdy got=%b exp=0001", c,
                 {bus5.busy, bus5.mux_e, bus5.done, bus5.in_ready});
      end
    end
  endtask

  task automatic test_single();
    logic         e, s, d;
    logic [W-1:0] y;
    bus5.in_a = 4'b0100; bus5.in_b = 4'b1011; bus5.in_valid = 1'b1;
    step();
    bus5.in_valid = 1'b0; bus5.in_a = 4'hF; bus5.in_b = 4'hF;
    for (int c = 1; c <= 15; c++) begin
      e = (c <= 10);
      s = (c >= 6 && c <= 10);
      d = (c == 15);
      y = (c <= 5) ? 4'b0100 : ((c <= 10) ? 4'b1011 : 4'b0000);
      checks++;
      if ({bus5.busy, bus5.mux_e, bus5.mux_s, bus5.done, bus5.in_ready, y5} !== {1'b1, e, s, d, 1'b1, y}) begin
        failures++;
        $display("FAIL single_cyc%0d busy/e/s/done/rdy/y got=%b exp=%b", c,
                 {bus5.busy, bus5.mux_e, bus5.mux_s, bus5.done, bus5.in_ready, y5}, {1'b1, e, s, d, 1'b1, y});
      end
      step();
    end
    checks++;
    if ({bus5.busy, bus5.mux_e, bus5.done, bus5.in_ready, bus5.mux_a, bus5.mux_b} !== {4'b0001, 4'b0100, 4'b1011}) begin
      failures++;
      $display("FAIL single_idle got=%b exp=%b", {bus5.busy, bus5.mux_e, bus5.done, bus5.in_ready,
               bus5.mux_a, bus5.mux_b}, {4'b0001, 4'b0100, 4'b1011});
    end
  endtask

  task automatic test_back_to_back();
    logic         e, s, d, r;
    logic [W-1:0] y;
    int           cc;
    bus5.in_a = 4'b0100; bus5.in_b = 4'b1011; bus5.in_valid = 1'b1;
    step();
    bus5.in_valid = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      cc = (c - 1) % 15 + 1;
      e  = (cc <= 10);
      s  = (cc >= 6 && cc <= 10);
      d  = (cc == 15);
      r  = !(c >= 8 && c <= 15);
      if (cc <= 5)       y = (c <= 15) ? 4'b0100 : 4'b1001;
      else if (cc <= 10) y = (c <= 15) ? 4'b1011 : 4'b0010;
      else               y = 4'b0000;
      checks++;
      if ({bus5.busy, bus5.mux_e, bus5.mux_s, bus5.done, bus5.in_ready, y5} !== {1'b1, e, s, d, r, y}) begin
        failures++;
        $display("FAIL b2b_cyc%0d busy/e/s/done/rdy/y got=%b exp=%b", c,
                 {bus5.busy, bus5.mux_e, bus5.mux_s, bus5.done, bus5.in_ready, y5}, {1'b1, e, s, d, r, y});
      end
      if (c == 7) begin
        bus5.in_a = 4'b1001; bus5.in_b = 4'b0010; bus5.in_valid = 1'b1;
      end else if (c == 8) begin
        bus5.in_valid = 1'b0; bus5.in_a = 4'hC; bus5.in_b = 4'h3;
      end
      step();
    end
    checks++;
    if ({bus5.busy, bus5.in_ready, bus5.mux_a} !== {2'b01, 4'b1001}) begin
      failures++;
      $display("FAIL b2b_end busy/rdy/a got=%b exp=%b", {bus5.busy, bus5.in_ready, bus5.mux_a}, {2'b01, 4'b1001});
    end
  endtask

  task automatic test_bypass();
    bus5.in_a = 4'b0100; bus5.in_b = 4'b1011; bus5.in_valid = 1'b1;
    step();
    bus5.in_valid = 1'b0;
    for (int c = 1; c < 15; c++) step();
    checks++;
    if ({bus5.done, bus5.in_ready, bus5.mux_e} !== 3'b110) begin
      failures++;
      $display("FAIL bypass_last_off done/rdy/e got=%b exp=110", {bus5.done, bus5.in_ready, bus5.mux_e});
    end
    bus5.in_a = 4'b0110; bus5.in_b = 4'b1100; bus5.in_valid = 1'b1;
    step();
    bus5.in_valid = 1'b0; bus5.in_a = 4'h0; bus5.in_b = 4'h0;
    checks++;
    if ({bus5.busy, bus5.mux_e, bus5.mux_s, bus5.in_ready, bus5.mux_a, bus5.mux_b} !== {4'b1101, 4'b0110, 4'b1100}) begin
      failures++;
      $display("FAIL bypass_phase_a got=%b exp=%b", {bus5.busy, bus5.mux_e, bus5.mux_s, bus5.in_ready,
               bus5.mux_a, bus5.mux_b}, {4'b1101, 4'b0110, 4'b1100});
    end
    for (int c = 2; c <= 15; c++) step();
    checks++;
    if ({bus5.done, bus5.mux_e, y5} !== {2'b10, 4'b0000}) begin
      failures++;
      $display("FAIL bypass_done got=%b exp=%b", {bus5.done, bus5.mux_e, y5}, {2'b10, 4'b0000});
    end
    step();
    checks++;
    if (bus5.busy !== 1'b0) begin
      failures++;
      $display("FAIL bypass_idle busy got=%b exp=0", bus5.busy);
    end
  endtask

  task automatic test_reset_mid();
    int done_seen = 0;
    int e_seen = 0;
    bus5.in_a = 4'b0100; bus5.in_b = 4'b1011; bus5.in_valid = 1'b1;
    step();
    bus5.in_valid = 1'b0;
    step();
    bus5.in_a = 4'b1001; bus5.in_b = 4'b0010; bus5.in_valid = 1'b1;
    step();
    bus5.in_valid = 1'b0; bus5.in_a = 4'h0; bus5.in_b = 4'h0;
    for (int c = 3; c < 8; c++) step();
    checks++;
    if ({bus5.mux_e, bus5.mux_s, bus5.in_ready} !== 3'b110) begin
      failures++;
      $display("FAIL rstmid_before e/s/rdy got=%b exp=110", {bus5.mux_e, bus5.mux_s, bus5.in_ready});
    end
    rst = 1'b1;
    step();
    checks++;
    if ({bus5.busy, bus5.mux_e, bus5.mux_s, bus5.done, bus5.in_ready, bus5.mux_a, bus5.mux_b} !== 13'b0) begin
      failures++;
      $display("FAIL rstmid_after got=%b exp=%b", {bus5.busy, bus5.mux_e, bus5.mux_s, bus5.done,
               bus5.in_ready, bus5.mux_a, bus5.mux_b}, 13'b0);
    end
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus5.done) done_seen++;
      if (bus5.mux_e || bus5.busy) e_seen++;
    end
    checks++;
    if ({done_seen, e_seen} !== {32'd0, 32'd0}) begin
      failures++;
      $display("FAIL rstmid_pending_dropped done_cycles=%0d active_cycles=%0d exp=0/0", done_seen, e_seen);
    end
  endtask

  task automatic test_dwell1();
    bus1.in_a = 4'b0011; bus1.in_b = 4'b0101; bus1.in_valid = 1'b1;
    step();
    bus1.in_valid = 1'b0;
    checks++;
    if ({bus1.busy, bus1.mux_e, bus1.mux_s, bus1.done, y1} !== {4'b1100, 4'b0011}) begin
      failures++;
      $display("FAIL d1_phase_a got=%b exp=%b", {bus1.busy, bus1.mux_e, bus1.mux_s, bus1.done, y1}, {4'b1100, 4'b0011});
    end
    step();
    checks++;
    if ({bus1.busy, bus1.mux_e, bus1.mux_s, bus1.done, y1} !== {4'b1110, 4'b0101}) begin
      failures++;
      $display("FAIL d1_phase_b got=%b exp=%b", {bus1.busy, bus1.mux_e, bus1.mux_s, bus1.done, y1}, {4'b1110, 4'b0101});
    end
    step();
    checks++;
    if ({bus1.busy, bus1.mux_e, bus1.mux_s, bus1.done} !== 4'b1001) begin
      failures++;
      $display("FAIL d1_phase_off got=%b exp=1001", {bus1.busy, bus1.mux_e, bus1.mux_s, bus1.done});
    end
    step();
    checks++;
    if ({bus1.busy, bus1.done, bus1.in_ready} !== 3'b001) begin
      failures++;
      $display("FAIL d1_idle busy/done/rdy got=%b exp=001", {bus1.busy, bus1.done, bus1.in_ready});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_bypass();
    test_reset_mid();
    test_dwell1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
